// File: rtl/mem_access_unit.sv
// Purpose: single-beat memory access sequencer between a multicycle controller and a ready-handshaked bus.
// Latency: request cycle N, busReady at N+1 -> DONE and readData valid at N+2.
// Backpressure: stall holds the controller while a request is pending; a bus silent for TIMEOUT wait cycles faults.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   memRead, memWrite    controller requests, sampled only in IDLE
//   adr, writeData       byte address (must be word aligned) and store data
//   readData             memory data register, updated only by a completed read
//   stall                combinational hold to the controller
//   error                sticky fault flag, cleared only by rst
//   busAdr, busWdata     latched word address and store data, stable for the whole wait
//   busRe, busWe         bus strobes, decoded from the registered state
//   busRdata, busReady   bus read data and completion
module mem_access_unit #(
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        memRead,
    input  logic        memWrite,
    input  logic [31:0] adr,
    input  logic [31:0] writeData,
    output logic [31:0] readData,
    output logic        stall,
    output logic        error,
    output logic [29:0] busAdr,
    output logic [31:0] busWdata,
    output logic        busRe,
    output logic        busWe,
    input  logic [31:0] busRdata,
    input  logic        busReady
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_WAIT = 3'd1,
        WR_WAIT = 3'd2,
        DONE    = 3'd3,
        FAULT   = 3'd4
    } state_t;

    // Counter value at the start of the last permitted wait cycle.
    localparam logic [7:0] LP_LAST = 8'(TIMEOUT - 1);

    state_t      r_state;
    logic [7:0]  r_cnt;
    logic [31:0] r_rdata;
    logic        r_error;
    logic [29:0] r_adr;
    logic [31:0] r_wdata;

    logic w_req;
    logic w_legal;

    assign w_req   = memRead | memWrite;
    // Exactly one request, word aligned.
    assign w_legal = (memRead ^ memWrite) && (adr[1:0] == 2'b00);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= 8'd0;
            r_rdata <= 32'd0;
            r_error <= 1'b0;
            r_adr   <= 30'd0;
            r_wdata <= 32'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_req) begin
                        if (w_legal) begin
                            r_adr <= adr[31:2];
                            r_cnt <= 8'd0;
                            if (memWrite) begin
                                r_wdata <= writeData;
                                r_state <= WR_WAIT;
                            end else begin
                                r_state <= RD_WAIT;
                            end
                        end else begin
                            r_state <= FAULT;
                            r_error <= 1'b1;
                        end
                    end
                end
                RD_WAIT, WR_WAIT: begin
                    // Ready is checked first so a completion on the last
                    // permitted cycle still finishes normally.
                    if (busReady) begin
                        if (r_state == RD_WAIT) begin
                            r_rdata <= busRdata;
                        end
                        r_state <= DONE;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                        if (r_cnt == LP_LAST) begin
                            r_state <= FAULT;
                            r_error <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    // FAULT is terminal; unused encodings fall into it too.
                    r_state <= FAULT;
                    r_error <= 1'b1;
                end
            endcase
        end
    end

    assign readData = r_rdata;
    assign error    = r_error;
    assign busAdr   = r_adr;
    assign busWdata = r_wdata;
    assign busRe    = (r_state == RD_WAIT);
    assign busWe    = (r_state == WR_WAIT);

    always_comb begin
        stall = 1'b0;
        case (r_state)
            IDLE:                    stall = w_req;
            RD_WAIT, WR_WAIT, FAULT: stall = 1'b1;
            default:                 stall = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        memRead, memWrite;
    logic [31:0] adr, writeData;
    logic [31:0] readData;
    logic        stall, error;
    logic [29:0] busAdr;
    logic [31:0] busWdata;
    logic        busRe, busWe;
    logic [31:0] busRdata;
    logic        busReady;

    int checks = 0;
    int errors = 0;

    logic [31:0] sb_rdata[$];
    logic [31:0] sb_adr[$];

    int  n_stall, n_re, n_we, end_cyc, how;
    bit  hold_ok;

    always #5 clk = ~clk;

    mem_access_unit #(.TIMEOUT(15)) dut (
        .clk      (clk),
        .rst      (rst),
        .memRead  (memRead),
        .memWrite (memWrite),
        .adr      (adr),
        .writeData(writeData),
        .readData (readData),
        .stall    (stall),
        .error    (error),
        .busAdr   (busAdr),
        .busWdata (busWdata),
        .busRe    (busRe),
        .busWe    (busWe),
        .busRdata (busRdata),
        .busReady (busReady)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drives one request in cycle 0, then busReady in wait cycle delay+1.
    // how: 0 completed (stall dropped), 1 faulted, 2 cycle budget expired.
    task automatic access(input logic rd, input logic wr, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] rdat, input int delay,
                          output int o_stall, output int o_re, output int o_we,
                          output int o_end, output int o_how, output bit o_hold);
        logic [29:0] a0;
        logic [31:0] w0;
        bit seen;
        o_stall = 0; o_re = 0; o_we = 0; o_end = -1; o_how = 2; o_hold = 1'b1;
        seen = 1'b0; a0 = '0; w0 = '0;
        @(negedge clk);
        memRead = rd; memWrite = wr; adr = a; writeData = wd;
        busReady = 1'b0; busRdata = rdat;
        for (int k = 0; k < 64; k++) begin
            if (k > 0) begin
                @(negedge clk);
                memRead = 1'b0; memWrite = 1'b0;
                busReady = (k == delay + 1);
            end
            #1;
            if (error) begin o_how = 1; o_end = k; break; end
            if (!stall) begin o_how = 0; o_end = k; break; end
            o_stall++;
            if (busRe) o_re++;
            if (busWe) o_we++;
            if (busRe || busWe) begin
                if (!seen) begin
                    a0 = busAdr; w0 = busWdata; seen = 1'b1;
                end else if (busAdr !== a0 || busWdata !== w0) begin
                    o_hold = 1'b0;
                end
            end
        end
        busReady = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; memRead = 1'b0; memWrite = 1'b0; busReady = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    initial begin
        rst = 1'b1; memRead = 1'b0; memWrite = 1'b0; adr = '0; writeData = '0;
        busRdata = '0; busReady = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_readData", readData, 32'h0);
        chk("rst_error", error, 32'h0);
        chk("rst_stall", stall, 32'h0);
        chk("rst_busRe", busRe, 32'h0);
        chk("rst_busWe", busWe, 32'h0);
        chk("rst_busAdr", busAdr, 32'h0);
        chk("rst_busWdata", busWdata, 32'h0);

        // Minimum-latency read.
        sb_rdata.push_back(32'hDEAD_BEEF); sb_adr.push_back(32'h4);
        access(1'b1, 1'b0, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, 0, n_stall, n_re, n_we, end_cyc, how, hold_ok);
        chk("rd_how", how, 0);
        chk("rd_done_cycle", end_cyc, 2);
        chk("rd_stall_cycles", n_stall, 2);
        chk("rd_re_cycles", n_re, 1);
        chk("rd_we_cycles", n_we, 0);
        chk("rd_readData", readData, sb_rdata.pop_front());
        chk("rd_busAdr", busAdr, sb_adr.pop_front());

        // Write with three cycles of bus delay.
        sb_rdata.push_back(32'hDEAD_BEEF); sb_adr.push_back(32'h9);
        access(1'b0, 1'b1, 32'h0000_0024, 32'h1234_5678, 32'hFFFF_FFFF, 3, n_stall, n_re, n_we, end_cyc, how, hold_ok);
        chk("wr_how", how, 0);
        chk("wr_we_cycles", n_we, 4);
        chk("wr_re_cycles", n_re, 0);
        chk("wr_stall_cycles", n_stall, 5);
        chk("wr_hold", hold_ok, 1);
        chk("wr_busAdr", busAdr, sb_adr.pop_front());
        chk("wr_busWdata", busWdata, 32'h1234_5678);
        chk("wr_readData", readData, sb_rdata.pop_front());

        // Ready arrives on the 15th wait cycle: normal completion.
        sb_rdata.push_back(32'hCAFE_0001);
        access(1'b1, 1'b0, 32'h0000_0040, 32'h0, 32'hCAFE_0001, 14, n_stall, n_re, n_we, end_cyc, how, hold_ok);
        chk("lim_how", how, 0);
        chk("lim_re_cycles", n_re, 15);
        chk("lim_hold", hold_ok, 1);
        chk("lim_error", error, 0);
        chk("lim_readData", readData, sb_rdata.pop_front());

        // A request present during DONE is ignored (misaligned would fault).
        sb_rdata.push_back(32'h0BAD_F00D);
        access(1'b1, 1'b0, 32'h0000_0070, 32'h0, 32'h0BAD_F00D, 0, n_stall, n_re, n_we, end_cyc, how, hold_ok);
        memRead = 1'b1; adr = 32'h0000_0003;
        #1;
        chk("done_stall", stall, 0);
        @(negedge clk);
        memRead = 1'b0;
        #1;
        chk("done_ign_error", error, 0);
        chk("done_ign_busRe", busRe, 0);
        chk("done_ign_stall", stall, 0);
        chk("done_readData", readData, sb_rdata.pop_front());

        // Reset in the middle of a read.
        @(negedge clk);
        memRead = 1'b1; adr = 32'h0000_0060; busReady = 1'b0;
        #1;
        chk("mid_req_stall", stall, 1);
        @(negedge clk);
        memRead = 1'b0;
        #1;
        chk("mid_busRe", busRe, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mid_rst_busRe", busRe, 0);
        chk("mid_rst_readData", readData, 32'h0);
        chk("mid_rst_error", error, 0);
        chk("mid_rst_stall", stall, 0);
        // busReady in IDLE is ignored.
        @(negedge clk);
        busReady = 1'b1; busRdata = 32'hFFFF_FFFF;
        @(negedge clk);
        busReady = 1'b0;
        #1;
        chk("idle_rdy_readData", readData, 32'h0);
        chk("idle_rdy_stall", stall, 0);

        // Simultaneous read and write requests.
        access(1'b1, 1'b1, 32'h0000_0008, 32'h5, 32'h0, 100, n_stall, n_re, n_we, end_cyc, how, hold_ok);
        chk("both_how", how, 1);
        chk("both_fault_cycle", end_cyc, 1);
        chk("both_strobes", n_re + n_we, 0);
        chk("both_stall", stall, 1);
        // Inputs are ignored in FAULT.
        @(negedge clk);
        memRead = 1'b1; adr = 32'h0000_0010; busReady = 1'b1;
        #1;
        chk("fault_ign_busRe", busRe, 0);
        chk("fault_ign_error", error, 1);
        do_reset();
        chk("both_rst_error", error, 0);

        // Misaligned read.
        access(1'b1, 1'b0, 32'h0000_0002, 32'h0, 32'h0, 100, n_stall, n_re, n_we, end_cyc, how, hold_ok);
        chk("mis_how", how, 1);
        chk("mis_fault_cycle", end_cyc, 1);
        chk("mis_strobes", n_re + n_we, 0);
        do_reset();

        // Timeout: bus never answers.
        access(1'b1, 1'b0, 32'h0000_0080, 32'h0, 32'h0, 1000, n_stall, n_re, n_we, end_cyc, how, hold_ok);
        chk("to_how", how, 1);
        chk("to_re_cycles", n_re, 15);
        chk("to_fault_cycle", end_cyc, 16);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            busReady = (i == 2);
            #1;
            chk("to_persist_error", error, 1);
            chk("to_persist_stall", stall, 1);
            chk("to_persist_strobes", {busRe, busWe}, 0);
        end
        do_reset();
        chk("to_rst_error", error, 0);
        chk("to_rst_stall", stall, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter TIMEOUT, default 15, meaning the maximum number of wait cycles before an access is aborted (range 1..255).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port memRead, input, 1 bit: read request from the multicycle controller.
REQ-005 SHALL have port memWrite, input, 1 bit: write request from the multicycle controller.
REQ-006 SHALL have port adr, input, 32 bits: byte address, already selected by the controller's IorD mux.
REQ-007 SHALL have port writeData, input, 32 bits: store data.
REQ-008 SHALL have port readData, output, 32 bits: registered read result, the memory data register.
REQ-009 SHALL have port stall, output, 1 bit: while high, the controller holds its present state.
REQ-010 SHALL have port error, output, 1 bit: sticky bus-fault flag.
REQ-011 SHALL have port busAdr, output, 30 bits: word address, equal to latched adr[31:2].
REQ-012 SHALL have port busWdata, output, 32 bits: latched store data.
REQ-013 SHALL have port busRe, output, 1 bit: bus read strobe.
REQ-014 SHALL have port busWe, output, 1 bit: bus write strobe.
REQ-015 SHALL have port busRdata, input, 32 bits: bus read data, valid when busReady is high.
REQ-016 SHALL have port busReady, input, 1 bit: bus completion, sampled once per cycle.

Function
REQ-017 SHALL implement the FSM states IDLE, RD_WAIT, WR_WAIT, DONE and FAULT.
REQ-018 IDLE with memRead=1, memWrite=0 and adr[1:0]=00: SHALL latch adr, then go to RD_WAIT.
REQ-019 IDLE with memWrite=1, memRead=0 and adr[1:0]=00: SHALL latch adr and writeData, then go to WR_WAIT.
REQ-020 IDLE with memRead=memWrite=1, or with either request high and adr[1:0]!=00: SHALL go to FAULT with no bus strobe issued.
REQ-021 IDLE with no request: SHALL remain in IDLE.
REQ-022 busRe SHALL be 1 only in RD_WAIT; busWe SHALL be 1 only in WR_WAIT; both decoded from registered state only.
REQ-023 busAdr and busWdata SHALL hold their latched values, unchanged, for the whole of the WAIT state.
REQ-024 In RD_WAIT with busReady=1: SHALL load readData from busRdata and go to DONE.
REQ-025 In WR_WAIT with busReady=1: SHALL go to DONE with readData unchanged.
REQ-026 Wait counter:
- 8 bits, cleared on entry to any WAIT state;
- increments each WAIT cycle in which busReady=0;
- when it reaches TIMEOUT with busReady=0: FSM SHALL go to FAULT.
REQ-027 busReady=1 in the same cycle the counter reaches TIMEOUT SHALL complete normally; ready wins.
REQ-028 DONE SHALL last exactly one cycle, then go to IDLE; requests present during DONE SHALL be ignored.
REQ-029 stall SHALL be combinational and equal to 1 in each of these cases:
- state IDLE with memRead or memWrite high;
- state RD_WAIT or WR_WAIT;
- state FAULT.
It SHALL be 0 otherwise.
REQ-030 FAULT SHALL be terminal until rst: error=1, stall=1, busRe=busWe=0, inputs ignored.
REQ-031 busReady in IDLE, DONE or FAULT SHALL be ignored.
REQ-032 Minimum latency: request at cycle N, busReady=1 at cycle N+1 SHALL give DONE at N+2 and readData valid from N+2; stall is high for cycles N and N+1.
REQ-033 readData SHALL hold its value until the next completed read.

Reset
REQ-034 When rst=1 at a clock edge, the FSM SHALL go to IDLE and the following SHALL be cleared to 0: counter, readData, error, busRe, busWe, busAdr, busWdata.
REQ-035 rst SHALL take priority over every transition, including mid-access and FAULT, and any in-flight access SHALL be abandoned.
REQ-036 stall SHALL be 0 in the cycle after reset if no request is present.

Verification
REQ-037 Read: adr=0x0000_0010, memRead=1; busReady=1 one cycle later with busRdata=0xDEAD_BEEF -> busAdr=0x4, readData=0xDEAD_BEEF at N+2, stall high exactly 2 cycles.
REQ-038 Write: adr=0x0000_0024, writeData=0x1234_5678; busReady delayed 3 cycles -> busWe high 4 cycles, busAdr=0x9, busWdata=0x1234_5678, readData unchanged.
REQ-039 Timeout: TIMEOUT=15, read with busReady held 0 -> FAULT after 15 wait cycles, error=1, stall=1, strobes 0; persists until rst.
REQ-040 Illegal requests: each of the following -> FAULT next cycle, busRe/busWe never asserted:
- memRead=memWrite=1;
- adr=0x0000_0002 with memRead=1.
REQ-041 Reset mid-access: rst=1 during RD_WAIT -> next cycle IDLE, readData=0, busRe=0, error=0.
REQ-042 Ready at limit: busReady=1 on the 15th wait cycle -> normal DONE, error stays 0.
